// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: descriptor stream in, instruction-memory write port out.
interface instr_encoder_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes LEGv8 descriptors and writes them to consecutive imem words.
// Optional ENC_RANGE_CHECK_EN rejects out-of-range immediates and invalid ops (sticky err).
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  instr_encoder_loader_if.slave      bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH+1)-1:0] word_count_o,
  output logic                       err_o
);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, we_q, we_d, ok, acc;
  logic [31:0]       wdata_q, wdata_d, enc;
  logic [25:0]       imm;
  assign imm = bus.in_imm;
  always_comb begin
    enc = '0;
    case (bus.in_op)
      4'd0: enc = {6'b000101, imm};
      4'd1: enc = {8'b01010100, imm[18:0], 1'b0, 4'b1011};
      4'd2: enc = {6'b100101, imm};
      4'd3: enc = {11'b11010110000, 5'b11111, 6'b000000, bus.in_rn, 5'b00000};
      4'd4: enc = {8'b10110100, imm[18:0], bus.in_rd};
      4'd5: enc = {10'b1001000100, imm[11:0], bus.in_rn, bus.in_rd};
      4'd6: enc = {11'b10101011000, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      4'd7: enc = {11'b11101011000, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      4'd8: enc = {11'b11111000010, imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
      4'd9: enc = {11'b11111000000, imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
      default: enc = '0;
    endcase
  end
`ifdef ENC_RANGE_CHECK_EN
  // signed fit: every bit from n-1 upward must equal the sign bit
  function automatic logic fits(input logic [25:0] v, input int n);
    logic [25:0] m;
    m = 26'h3FF_FFFF << (n - 1);
    return ((v & m) == '0) || ((v & m) == m);
  endfunction
  always_comb begin
    ok = 1'b0;
    case (bus.in_op)
      4'd0, 4'd2:       ok = fits(imm, 26);
      4'd1, 4'd4:       ok = fits(imm, 19);
      4'd3, 4'd6, 4'd7: ok = 1'b1;
      4'd5:             ok = imm[25:11] == '0;
      4'd8, 4'd9:       ok = fits(imm, 9);
      default:          ok = 1'b0;
    endcase
  end
`else
  assign ok = 1'b1;
`endif
  assign acc = bus.in_valid && (state_q == LOAD);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (acc) begin
      if (ok) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = enc;
        addr_d  = addr_q + ADDR_W'(4);
        cnt_d   = cnt_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
      if (bus.in_last || (ok && cnt_q == CW'(DEPTH - 1))) state_d = DONE;
    end else if (start_i && state_q != LOAD) begin
      state_d = LOAD;
      addr_d  = {base_addr_i[ADDR_W-1:2], 2'b00};
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.in_ready   = state_q == LOAD;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy_o         = state_q == LOAD;
  assign done_o         = state_q == DONE;
  assign word_count_o   = cnt_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and random sessions checked against an arithmetic reference model.
module tb_instr_encoder_loader;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, reset = 0, start = 0;
  logic [AW-1:0] base = '0;
  logic busy, done, err;
  logic [CW-1:0] wc;
  int vectors = 0, miscompares = 0;
  int m_state = 0, m_cnt = 0;
  bit m_err = 0;
  logic [AW-1:0] m_addr = '0;
  wr_t pend[$];
  logic [31:0] wlog_d[$];
  logic [AW-1:0] wlog_a[$];
  wr_t w;
  instr_encoder_loader_if #(.ADDR_W(AW)) bus();
  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_i(start), .base_addr_i(base), .bus(bus),
    .busy_o(busy), .done_o(done), .word_count_o(wc), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_enc(input int op, input logic [31:0] rd, rn, rm, input logic [25:0] imm);
    logic [31:0] i;
    i = 32'(imm);
    case (op)
      0: return (32'd5 << 26) | i;
      1: return (32'h54 << 24) | ((i & 32'h7FFFF) << 5) | 32'd11;
      2: return (32'd37 << 26) | i;
      3: return (32'h6B0 << 21) | (32'd31 << 16) | (rn << 5);
      4: return (32'hB4 << 24) | ((i & 32'h7FFFF) << 5) | rd;
      5: return (32'h244 << 22) | ((i & 32'hFFF) << 10) | (rn << 5) | rd;
      6: return (32'h558 << 21) | (rm << 16) | (rn << 5) | rd;
      7: return (32'h758 << 21) | (rm << 16) | (rn << 5) | rd;
      8: return (32'h7C2 << 21) | ((i & 32'h1FF) << 12) | (rn << 5) | rd;
      9: return (32'h7C0 << 21) | ((i & 32'h1FF) << 12) | (rn << 5) | rd;
      default: return 32'h0;
    endcase
  endfunction
  function automatic bit ref_ok(input int op, input logic [25:0] imm);
`ifdef ENC_RANGE_CHECK_EN
    int s;
    s = imm[25] ? int'(imm) - (1 << 26) : int'(imm);
    case (op)
      0, 2, 3, 6, 7: return 1;
      1, 4: return s >= -(1 << 18) && s < (1 << 18);
      5: return int'(imm) <= 2047;
      8, 9: return s >= -256 && s < 256;
      default: return 0;
    endcase
`else
    return 1;
`endif
  endfunction
  task automatic model_update();
    bit ok;
    if (!reset) begin
      m_state = 0; m_addr = '0; m_cnt = 0; m_err = 0;
      pend.delete();
    end else if (m_state == 1 && bus.in_valid) begin
      ok = ref_ok(int'(bus.in_op), bus.in_imm);
      if (ok) begin
        pend.push_back('{m_addr, ref_enc(int'(bus.in_op), 32'(bus.in_rd), 32'(bus.in_rn), 32'(bus.in_rm), bus.in_imm)});
        m_addr = m_addr + AW'(4);
        m_cnt++;
      end else m_err = 1;
      if (bus.in_last || (ok && m_cnt == DEPTH)) m_state = 2;
    end else if (m_state != 1 && start) begin
      m_state = 1; m_addr = base & ~AW'(3); m_cnt = 0; m_err = 0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic begin_s(input logic [AW-1:0] b);
    base = b; start = 1; step(); start = 0;
    wlog_d.delete(); wlog_a.delete();
  endtask
  task automatic beat(input int op, input int rd, input int rn, input int rm, input logic [25:0] imm, input bit last);
    bus.in_valid = 1; bus.in_op = 4'(op); bus.in_rd = 5'(rd); bus.in_rn = 5'(rn); bus.in_rm = 5'(rm);
    bus.in_imm = imm; bus.in_last = last;
    step();
  endtask
  task automatic idle(input int n);
    bus.in_valid = 0; bus.in_last = 0;
    repeat (n) step();
  endtask
  initial forever begin
    @(negedge clk);
    check("imem_we", 32'(bus.imem_we), 32'(pend.size() > 0));
    if (pend.size() > 0) begin
      w = pend.pop_front();
      if (bus.imem_we) begin
        check("imem_addr", 32'(bus.imem_addr), 32'(w.a));
        check("imem_wdata", bus.imem_wdata, w.d);
        wlog_d.push_back(bus.imem_wdata);
        wlog_a.push_back(bus.imem_addr);
      end
    end
    check("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("word_count", 32'(wc), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
  end
  initial begin
    int nb;
    bus.in_valid = 0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0;
    bus.in_imm = '0; bus.in_last = 0;
    repeat (3) step();
    reset = 1;
    check("rst_addr", 32'(bus.imem_addr), 32'h0);
    check("rst_wdata", bus.imem_wdata, 32'h0);
    step();
    begin_s(10'h040);
    beat(5, 1, 31, 0, 26'd5, 0);
    beat(7, 2, 1, 1, 26'd0, 1);
    idle(2);
    check("addi_word", wlog_d[0], 32'h910017E1);
    check("addi_addr", 32'(wlog_a[0]), 32'h040);
    check("subs_word", wlog_d[1], 32'hEB010022);
    check("subs_addr", 32'(wlog_a[1]), 32'h044);
    check("s1_done", 32'(done), 32'h1);
    check("s1_count", 32'(wc), 32'd2);
    begin_s(10'h100);
    beat(0, 0, 0, 0, 26'h3FFFFFF, 0);
    beat(8, 3, 2, 0, 26'd8, 0);
    beat(3, 0, 30, 0, 26'd0, 1);
    idle(2);
    check("b_word", wlog_d[0], 32'h17FFFFFF);
    check("ldur_word", wlog_d[1], 32'hF8408043);
    check("br_word", wlog_d[2], 32'hD61F03C0);
    begin_s(10'h200);
    for (int i = 0; i < 6; i++) beat(6, i, i + 1, i + 2, 26'd0, 0);
    idle(1);
    check("depth_writes", 32'(wlog_d.size()), 32'd4);
    check("depth_ready", 32'(bus.in_ready), 32'h0);
    check("depth_done", 32'(done), 32'h1);
    begin_s(10'h083);
    check("restart_count", 32'(wc), 32'd0);
    beat(6, 1, 1, 1, 26'd0, 1);
    idle(2);
    check("restart_addr", 32'(wlog_a[0]), 32'h080);
    begin_s(10'h000);
    beat(6, 1, 2, 3, 26'd0, 0);
    beat(5, 4, 5, 0, 26'h800, 0);
    beat(7, 1, 2, 3, 26'd0, 1);
    idle(2);
`ifdef ENC_RANGE_CHECK_EN
    check("rc_writes", 32'(wlog_d.size()), 32'd2);
    check("rc_addr2", 32'(wlog_a[1]), 32'h004);
    check("rc_err", 32'(err), 32'h1);
`else
    check("rc_writes", 32'(wlog_d.size()), 32'd3);
    check("rc_trunc", wlog_d[1], 32'h912000A4);
    check("rc_err", 32'(err), 32'h0);
`endif
    begin_s(10'h3FC);
    beat(6, 1, 2, 3, 26'd0, 0);
    beat(7, 1, 2, 3, 26'd0, 0);
    beat(12, 1, 2, 3, 26'd0, 1);
    idle(2);
    check("wrap_first", 32'(wlog_a[0]), 32'h3FC);
    check("wrap_second", 32'(wlog_a[1]), 32'h000);
`ifndef ENC_RANGE_CHECK_EN
    check("invalid_op", wlog_d[2], 32'h0);
`endif
    begin_s(10'h100);
    beat(6, 1, 1, 1, 26'd0, 0);
    base = 10'h300; start = 1;
    beat(6, 2, 2, 2, 26'd0, 0);
    start = 0;
    beat(6, 3, 3, 3, 26'd0, 1);
    idle(2);
    check("start_ignored", 32'(wlog_a[2]), 32'h108);
    begin_s(10'h000);
    beat(6, 1, 1, 1, 26'd0, 0);
    beat(6, 2, 2, 2, 26'd0, 0);
    reset = 0;
    beat(6, 3, 3, 3, 26'd0, 0);
    beat(6, 4, 4, 4, 26'd0, 0);
    check("mrst_we", 32'(bus.imem_we), 32'h0);
    check("mrst_ready", 32'(bus.in_ready), 32'h0);
    check("mrst_count", 32'(wc), 32'h0);
    reset = 1;
    idle(2);
    for (int s = 0; s < 40; s++) begin
      begin_s(AW'($urandom));
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        int op, k;
        logic [25:0] imm;
        if ($urandom_range(0, 3) == 0) idle(1);
        op = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        k = $urandom_range(0, 3);
        imm = k == 0 ? 26'($signed($urandom_range(0, 511)) - 256) :
              k == 1 ? 26'($urandom_range(0, 4095)) :
              k == 2 ? 26'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh3FFFF) : 26'($urandom);
        beat(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, i == nb - 1);
      end
      idle(2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
